// File: rtl/sad_min_tracker_if.sv
// sad_min_tracker_if: candidate-beat input bus and result bus of the SAD running-minimum tracker.
// Ports: the master side drives start/sad_valid/sad_last/sad_vec/mv_x/mv_y and receives
//        busy/done/min_sad/min_mv_x/min_mv_y/cand_cnt; the slave side (the tracker) is the mirror.
interface sad_min_tracker_if #(
  parameter int NUM_CH = 4,
  parameter int SAD_W  = 16,
  parameter int MV_W   = 8,
  parameter int CNT_W  = 12
);
  // Candidate beat side
  logic                      start;
  logic                      sad_valid;
  logic                      sad_last;
  logic [NUM_CH*SAD_W-1:0]   sad_vec;
  logic [MV_W-1:0]           mv_x;
  logic [MV_W-1:0]           mv_y;

  // Result side
  logic                      busy;
  logic                      done;
  logic [NUM_CH*SAD_W-1:0]   min_sad;
  logic [NUM_CH*MV_W-1:0]    min_mv_x;
  logic [NUM_CH*MV_W-1:0]    min_mv_y;
  logic [CNT_W-1:0]          cand_cnt;

  modport master (
    output start, sad_valid, sad_last, sad_vec, mv_x, mv_y,
    input  busy, done, min_sad, min_mv_x, min_mv_y, cand_cnt
  );

  modport slave (
    input  start, sad_valid, sad_last, sad_vec, mv_x, mv_y,
    output busy, done, min_sad, min_mv_x, min_mv_y, cand_cnt
  );
endinterface

// File: rtl/sad_min_tracker.sv
// sad_min_tracker: per-partition running minimum SAD with best-MV capture over a search sweep.
// Latency: an accepted beat / start is reflected on all outputs one cycle later; done pulses the
//          cycle after the last beat. One beat per cycle, no back-pressure.
// Ports: clk, rst (sync, active-high) plus bus (sad_min_tracker_if.slave) carrying start,
//        sad_valid, sad_last, sad_vec, mv_x, mv_y in and busy, done, min_sad, min_mv_x,
//        min_mv_y, cand_cnt out. All outputs come straight from flops.
// Build option: define SAD_MIN_TIEBREAK_EN to break equal-SAD ties in favour of the smaller
//               |mv_x|+|mv_y|; otherwise the earliest candidate keeps an equal SAD.
module sad_min_tracker #(
  parameter int NUM_CH = 4,
  parameter int SAD_W  = 16,
  parameter int MV_W   = 8,
  parameter int CNT_W  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  sad_min_tracker_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [SAD_W-1:0] SAD_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [SAD_W-1:0]   min_sad_q [NUM_CH];
  logic [SAD_W-1:0]   min_sad_d [NUM_CH];
  logic [MV_W-1:0]    min_mvx_q [NUM_CH];
  logic [MV_W-1:0]    min_mvx_d [NUM_CH];
  logic [MV_W-1:0]    min_mvy_q [NUM_CH];
  logic [MV_W-1:0]    min_mvy_d [NUM_CH];
  logic [CNT_W-1:0]   cand_cnt_q, cand_cnt_d;

  logic               accept;
  logic [NUM_CH-1:0]  win;

`ifdef SAD_MIN_TIEBREAK_EN
  // Magnitude at MV_W+1 bits so that -2^(MV_W-1) maps to +2^(MV_W-1) without wrapping.
  function automatic logic [MV_W:0] mv_mag(input logic [MV_W-1:0] v);
    logic [MV_W:0] ext;
    ext = {v[MV_W-1], v};
    return ext[MV_W] ? (~ext + 1'b1) : ext;
  endfunction

  function automatic logic [MV_W+1:0] mv_l1(input logic [MV_W-1:0] x,
                                            input logic [MV_W-1:0] y);
    return {1'b0, mv_mag(x)} + {1'b0, mv_mag(y)};
  endfunction

  logic [MV_W+1:0] cand_l1;
  assign cand_l1 = mv_l1(bus.mv_x, bus.mv_y);
`endif

  // Per-channel replace decision for the current candidate.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SAD_W-1:0] cand_sad;
    assign cand_sad = bus.sad_vec[c*SAD_W +: SAD_W];

`ifdef SAD_MIN_TIEBREAK_EN
    logic [MV_W+1:0] best_l1;
    assign best_l1 = mv_l1(min_mvx_q[c], min_mvy_q[c]);
    // The cleared value carries MV (0,0), so an all-ones beat can never win the tie.
    assign win[c] = (cand_sad < min_sad_q[c]) ||
                    ((cand_sad == min_sad_q[c]) && (cand_l1 < best_l1));
`else
    assign win[c] = cand_sad < min_sad_q[c];
`endif

    assign bus.min_sad [c*SAD_W +: SAD_W] = min_sad_q[c];
    assign bus.min_mv_x[c*MV_W  +: MV_W]  = min_mvx_q[c];
    assign bus.min_mv_y[c*MV_W  +: MV_W]  = min_mvy_q[c];
  end

  // Next-state and datapath. start overrides everything in every state: it clears the
  // sweep and (re)enters SEARCH, discarding any beat presented in the same cycle.
  always_comb begin
    state_d    = state_q;
    cand_cnt_d = cand_cnt_q;
    min_sad_d  = min_sad_q;
    min_mvx_d  = min_mvx_q;
    min_mvy_d  = min_mvy_q;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) state_d = SEARCH;
      end
      SEARCH: begin
        if (bus.start) begin
          state_d = SEARCH;
        end else if (bus.sad_valid) begin
          accept = 1'b1;
          if (bus.sad_last) state_d = DONE;
        end
      end
      DONE: begin
        state_d = bus.start ? SEARCH : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.start) begin
      cand_cnt_d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        min_sad_d[c] = SAD_MAX;
        min_mvx_d[c] = '0;
        min_mvy_d[c] = '0;
      end
    end else if (accept) begin
      if (cand_cnt_q != CNT_MAX) cand_cnt_d = cand_cnt_q + 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (win[c]) begin
          min_sad_d[c] = bus.sad_vec[c*SAD_W +: SAD_W];
          min_mvx_d[c] = bus.mv_x;
          min_mvy_d[c] = bus.mv_y;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cand_cnt_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        min_sad_q[c] <= SAD_MAX;
        min_mvx_q[c] <= '0;
        min_mvy_q[c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cand_cnt_q <= cand_cnt_d;
      for (int c = 0; c < NUM_CH; c++) begin
        min_sad_q[c] <= min_sad_d[c];
        min_mvx_q[c] <= min_mvx_d[c];
        min_mvy_q[c] <= min_mvy_d[c];
      end
    end
  end

  // busy/done decode straight from the state flops, so they remain registered outputs.
  assign bus.busy     = (state_q == SEARCH);
  assign bus.done     = (state_q == DONE);
  assign bus.cand_cnt = cand_cnt_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// tb_sad_min_tracker: directed and randomized sweeps against a history-based reference model.
// The model keeps every accepted beat of the current sweep and derives the expected minima
// by scanning that history; all DUT outputs are compared after every clock edge.
module tb_sad_min_tracker;
  localparam int NUM_CH = 4;
  localparam int SAD_W  = 16;
  localparam int MV_W   = 8;
  localparam int CNT_W  = 12;
  localparam int VW     = NUM_CH * SAD_W;
  localparam int SAD_MAX_I = (1 << SAD_W) - 1;
  localparam int CNT_MAX_I = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sad_min_tracker_if #(.NUM_CH(NUM_CH), .SAD_W(SAD_W), .MV_W(MV_W), .CNT_W(CNT_W)) bus();

  sad_min_tracker #(.NUM_CH(NUM_CH), .SAD_W(SAD_W), .MV_W(MV_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [VW-1:0] vec;
    int            mx;
    int            my;
  } beat_t;

  beat_t hist[$];
  int    exp_cnt;
  int    phase;      // 0 idle, 1 searching, 2 done cycle
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Index of the winning beat for channel c, or -1 if the cleared value still stands.
  function automatic int best_idx(input int c);
    int best;
    int bs;
    int s;
    best = -1;
    bs   = SAD_MAX_I;
    for (int i = 0; i < hist.size(); i++) begin
      s = int'(hist[i].vec[c*SAD_W +: SAD_W]);
      if (s < SAD_MAX_I) begin
        if (best < 0 || s < bs) begin
          best = i;
          bs   = s;
        end
`ifdef SAD_MIN_TIEBREAK_EN
        else if (s == bs && (iabs(hist[i].mx) + iabs(hist[i].my)) <
                            (iabs(hist[best].mx) + iabs(hist[best].my))) begin
          best = i;
        end
`endif
      end
    end
    return best;
  endfunction

  task automatic check_all(input bit full);
    logic [VW-1:0]          es;
    logic [NUM_CH*MV_W-1:0] ex;
    logic [NUM_CH*MV_W-1:0] ey;
    logic [MV_W-1:0]        t;
    int                     b;
    chk("cand_cnt", 64'(bus.cand_cnt), 64'(exp_cnt));
    if (full) begin
      for (int c = 0; c < NUM_CH; c++) begin
        b = best_idx(c);
        if (b < 0) begin
          es[c*SAD_W +: SAD_W] = '1;
          ex[c*MV_W +: MV_W]   = '0;
          ey[c*MV_W +: MV_W]   = '0;
        end else begin
          es[c*SAD_W +: SAD_W] = hist[b].vec[c*SAD_W +: SAD_W];
          t = MV_W'(hist[b].mx);
          ex[c*MV_W +: MV_W] = t;
          t = MV_W'(hist[b].my);
          ey[c*MV_W +: MV_W] = t;
        end
      end
      chk("busy",     64'(bus.busy),     64'(phase == 1));
      chk("done",     64'(bus.done),     64'(phase == 2));
      chk("min_sad",  64'(bus.min_sad),  64'(es));
      chk("min_mv_x", 64'(bus.min_mv_x), 64'(ex));
      chk("min_mv_y", 64'(bus.min_mv_y), 64'(ey));
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, compare.
  task automatic cyc(input bit r, input bit st, input bit v, input bit l,
                     input logic [VW-1:0] vec, input int mx, input int my, input bit full);
    beat_t bt;
    rst           = r;
    bus.start     = st;
    bus.sad_valid = v;
    bus.sad_last  = l;
    bus.sad_vec   = vec;
    bus.mv_x      = MV_W'(mx);
    bus.mv_y      = MV_W'(my);
    @(posedge clk);
    #1;
    if (r) begin
      hist.delete();
      exp_cnt = 0;
      phase   = 0;
    end else if (st) begin
      hist.delete();
      exp_cnt = 0;
      phase   = 1;
    end else if (phase == 1) begin
      if (v) begin
        bt.vec = vec;
        bt.mx  = mx;
        bt.my  = my;
        hist.push_back(bt);
        if (exp_cnt < CNT_MAX_I) exp_cnt++;
        if (l) phase = 2;
      end
    end else if (phase == 2) begin
      phase = 0;
    end
    check_all(full);
  endtask

  function automatic logic [VW-1:0] mkvec(input int s0, input int s1, input int s2, input int s3);
    logic [VW-1:0] v;
    v[0*SAD_W +: SAD_W] = SAD_W'(s0);
    v[1*SAD_W +: SAD_W] = SAD_W'(s1);
    v[2*SAD_W +: SAD_W] = SAD_W'(s2);
    v[3*SAD_W +: SAD_W] = SAD_W'(s3);
    return v;
  endfunction

  function automatic logic [VW-1:0] rvec(input int maxv);
    logic [VW-1:0] v;
    for (int c = 0; c < NUM_CH; c++) begin
      if ($urandom_range(0, 15) == 0) v[c*SAD_W +: SAD_W] = '1;
      else v[c*SAD_W +: SAD_W] = SAD_W'($urandom_range(0, maxv));
    end
    return v;
  endfunction

  function automatic int rmv();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  logic [VW-1:0] ones;

  initial begin
    exp_cnt = 0;
    phase   = 0;
    ones    = '1;

    // Reset state, then beats in IDLE must be ignored.
    cyc(1, 0, 0, 0, '0, 0, 0, 1);
    cyc(1, 0, 1, 1, mkvec(1, 2, 3, 4), 5, 5, 1);
    cyc(0, 0, 1, 0, mkvec(1, 2, 3, 4), 5, 5, 1);
    cyc(0, 0, 1, 1, mkvec(9, 9, 9, 9), -3, 2, 1);
    chk("idle_min_sad", 64'(bus.min_sad), 64'(ones));

    // Basic sweep on channel 0, plus independent minima on channels 1 and 2.
    cyc(0, 1, 0, 0, '0, 0, 0, 1);
    cyc(0, 0, 1, 0, mkvec(100, 5, 90, 300), 1, 1, 1);
    cyc(0, 0, 1, 0, mkvec(40, 8, 80, 200), -2, 3, 1);
    cyc(0, 0, 1, 1, mkvec(70, 9, 10, 250), 0, 0, 1);
    chk("basic_sad0", 64'(bus.min_sad[15:0]), 64'd40);
    chk("basic_mvx0", 64'(bus.min_mv_x[7:0]), 64'h00FE);
    chk("basic_mvy0", 64'(bus.min_mv_y[7:0]), 64'd3);
    chk("basic_mvx2", 64'(bus.min_mv_x[23:16]), 64'd0);
    chk("basic_done", 64'(bus.done), 64'd1);
    cyc(0, 0, 1, 0, mkvec(1, 1, 1, 1), 7, 7, 1);   // DONE cycle, beat ignored
    cyc(0, 0, 0, 0, '0, 0, 0, 1);

    // Tie on channel 0: earliest wins, or the smaller MV with the tie-break build.
    cyc(0, 1, 0, 0, '0, 0, 0, 1);
    cyc(0, 0, 1, 0, mkvec(50, 50, 50, 50), 4, 4, 1);
    cyc(0, 0, 1, 1, mkvec(50, 60, 50, 40), 1, 0, 1);
`ifdef SAD_MIN_TIEBREAK_EN
    chk("tie_mvx", 64'(bus.min_mv_x[7:0]), 64'd1);
`else
    chk("tie_mvx", 64'(bus.min_mv_x[7:0]), 64'd4);
`endif

    // Abort: start with a valid beat mid-sweep discards the beat and clears everything.
    cyc(0, 1, 0, 0, '0, 0, 0, 1);
    cyc(0, 0, 1, 0, mkvec(10, 20, 30, 40), 3, -3, 1);
    cyc(0, 1, 1, 1, mkvec(1, 1, 1, 1), 2, 2, 1);
    chk("abort_cnt", 64'(bus.cand_cnt), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd1);
    cyc(0, 0, 1, 1, mkvec(SAD_MAX_I, 7, 7, 7), -128, 127, 1);
    cyc(0, 0, 0, 0, '0, 0, 0, 1);

    // Reset mid-sweep, then a complete independent sweep.
    cyc(0, 1, 0, 0, '0, 0, 0, 1);
    cyc(0, 0, 1, 0, mkvec(3, 3, 3, 3), 9, 9, 1);
    cyc(1, 0, 1, 0, mkvec(2, 2, 2, 2), 8, 8, 1);
    cyc(0, 1, 0, 0, '0, 0, 0, 1);
    cyc(0, 0, 1, 0, mkvec(500, 400, 300, 200), -1, -1, 1);
    cyc(0, 0, 1, 1, mkvec(600, 100, 300, 100), 6, -6, 1);
    cyc(0, 0, 0, 0, '0, 0, 0, 1);

    // Randomized sweeps: gaps, ties, all-ones SADs, aborts, restart in the DONE cycle.
    for (int s = 0; s < 60; s++) begin
      int n;
      int k;
      int guard;
      bit v;
      cyc(0, 1, $urandom_range(0, 1), 0, rvec(30), rmv(), rmv(), 1);
      n = $urandom_range(1, 20);
      k = 0;
      guard = 0;
      while (k < n && guard < 200) begin
        guard++;
        v = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 40) == 0) begin
          cyc(0, 1, v, 0, rvec(30), rmv(), rmv(), 1);
          k = 0;
        end else begin
          cyc(0, 0, v, v && (k == n - 1), rvec(30), rmv(), rmv(), 1);
          if (v) k++;
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        cyc(0, 1, 1, 0, rvec(30), rmv(), rmv(), 1);   // restart during DONE
      end else begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++)
          cyc(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), rvec(30), rmv(), rmv(), 1);
      end
    end

    // Counter saturation over a long sweep.
    cyc(0, 1, 0, 0, '0, 0, 0, 1);
    for (int i = 0; i < CNT_MAX_I + 4; i++)
      cyc(0, 0, 1, 0, rvec(60000), rmv(), rmv(), 0);
    chk("cnt_sat", 64'(bus.cand_cnt), 64'(CNT_MAX_I));
    cyc(0, 0, 1, 1, rvec(60000), rmv(), rmv(), 1);
    cyc(0, 0, 0, 0, '0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
